aoi221_arc_exerciser: RTL and testbench

- Self-checking sequencer that drives every conditional timing arc of an AOI221 cell (ZN = !((C1&C2) | (B1&B2) | A)) and checks the returned ZN.
- For each arc it applies the sensitizing side-input condition, toggles the target pin rise then fall, and compares ZN against the expected inversion.
- Sits beside a cell instance in characterization and gate-level sign-off benches; it is the stimulus/response end of the cell's arc list.

---
 rtl/aoi221_arc_pkg.sv | 36 +++
 rtl/aoi221_arc_phase_timer.sv | 28 ++
 rtl/aoi221_arc_exerciser.sv | 137 +++++++++++++
 tb/tb_aoi221_arc_exerciser.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/aoi221_arc_pkg.sv
// Shared types and the arc table for the AOI221 timing-arc exerciser.
// Pin vectors are ordered {A,B1,B2,C1,C2}; target index 0..4 follows that order.
package aoi221_arc_pkg;

  localparam int NUM_ARCS = 21;
  localparam logic [4:0] LAST_ARC = 5'd20;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    RISE,
    FALL,
    FIN
  } state_t;

  typedef struct packed {
    logic [2:0] target;
    logic [4:0] base;
  } arc_t;

  // Each base holds the sensitizing side inputs with the target pin at 0.
  localparam arc_t ARC_TABLE [NUM_ARCS] = '{
    '{3'd0, 5'b00000}, '{3'd0, 5'b00001}, '{3'd0, 5'b00010},
    '{3'd0, 5'b00100}, '{3'd0, 5'b00101}, '{3'd0, 5'b00110},
    '{3'd0, 5'b01000}, '{3'd0, 5'b01001}, '{3'd0, 5'b01010},
    '{3'd1, 5'b00100}, '{3'd1, 5'b00101}, '{3'd1, 5'b00110},
    '{3'd2, 5'b01000}, '{3'd2, 5'b01001}, '{3'd2, 5'b01010},
    '{3'd3, 5'b00001}, '{3'd3, 5'b00101}, '{3'd3, 5'b01001},
    '{3'd4, 5'b00010}, '{3'd4, 5'b00110}, '{3'd4, 5'b01010}
  };

  function automatic logic [4:0] target_mask(input logic [2:0] target);
    return 5'b10000 >> target;
  endfunction

endpackage

// File: rtl/aoi221_arc_phase_timer.sv
// Phase timer: counts 0..SETTLE inside each phase, flags the first cycle
// of a phase (phase_start) and the ZN sampling cycle (sample_now).
module aoi221_arc_phase_timer #(
  parameter int SETTLE = 2
) (
  input  logic CK,
  input  logic RST,
  input  logic run,
  output logic phase_start,
  output logic sample_now
);

  localparam logic [3:0] LAST_CNT = 4'(SETTLE);

  logic [3:0] cnt;

  always_ff @(posedge CK) begin
    if (RST || !run || cnt == LAST_CNT) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 4'd1;
    end
  end

  assign phase_start = run && (cnt == 4'd0);
  assign sample_now  = run && (cnt == LAST_CNT);

endmodule

// File: rtl/aoi221_arc_exerciser.sv
// Drives every conditional arc of an AOI221 cell and checks the returned ZN.
// Optional AOI221_ARC_HALT_EN: stop at the first failing check with drives held.
module aoi221_arc_exerciser #(
  parameter int SETTLE = 2
) (
  input  logic       CK,
  input  logic       RST,
  input  logic       START,
  input  logic       ZN_IN,
  output logic       A,
  output logic       B1,
  output logic       B2,
  output logic       C1,
  output logic       C2,
  output logic       BUSY,
  output logic       DONE,
  output logic       PASS,
  output logic [5:0] ERR_CNT,
  output logic [4:0] ARC_IDX
);

  import aoi221_arc_pkg::*;

  state_t     state;
  logic [4:0] drive;
  logic       zn_q;
  logic       exp_q;
  logic       run;
  logic       phase_start;
  logic       sample_now;
  logic       miss;
  logic       halt_now;
  logic [4:0] nxt_idx;
  arc_t       cur_arc;
  arc_t       nxt_arc;

  function automatic logic [5:0] sat_inc(input logic [5:0] v);
    return (v == 6'h3F) ? v : v + 6'd1;
  endfunction

  assign {A, B1, B2, C1, C2} = drive;

  assign run     = (state == SETUP) || (state == RISE) || (state == FALL);
  assign nxt_idx = (ARC_IDX == LAST_ARC) ? ARC_IDX : ARC_IDX + 5'd1;
  assign cur_arc = ARC_TABLE[ARC_IDX];
  assign nxt_arc = ARC_TABLE[nxt_idx];
  assign miss    = sample_now && (zn_q != exp_q);

`ifdef AOI221_ARC_HALT_EN
  assign halt_now = miss;
`else
  assign halt_now = 1'b0;
`endif

  aoi221_arc_phase_timer #(
    .SETTLE(SETTLE)
  ) u_timer (
    .CK         (CK),
    .RST        (RST),
    .run        (run),
    .phase_start(phase_start),
    .sample_now (sample_now)
  );

  // Response path: ZN registered once; expectation latched at phase start
  // (ZN must be low only while the target pin is high).
  always_ff @(posedge CK) begin
    zn_q <= ZN_IN;
    if (phase_start) begin
      exp_q <= (state != RISE);
    end
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      state   <= IDLE;
      drive   <= '0;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      PASS    <= 1'b0;
      ERR_CNT <= '0;
      ARC_IDX <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (START) begin
            state   <= SETUP;
            drive   <= ARC_TABLE[0].base;
            BUSY    <= 1'b1;
            DONE    <= 1'b0;
            PASS    <= 1'b0;
            ERR_CNT <= '0;
            ARC_IDX <= '0;
          end
        end
        SETUP, RISE, FALL: begin
          if (sample_now) begin
            if (miss) begin
              ERR_CNT <= sat_inc(ERR_CNT);
            end
            if (halt_now) begin
              state <= FIN;
            end else begin
              case (state)
                SETUP: begin
                  state <= RISE;
                  drive <= cur_arc.base | target_mask(cur_arc.target);
                end
                RISE: begin
                  state <= FALL;
                  drive <= cur_arc.base;
                end
                default: begin
                  if (ARC_IDX == LAST_ARC) begin
                    state <= FIN;
                  end else begin
                    state   <= SETUP;
                    ARC_IDX <= nxt_idx;
                    drive   <= nxt_arc.base;
                  end
                end
              endcase
            end
          end
        end
        FIN: begin
          state <= IDLE;
          BUSY  <= 1'b0;
          DONE  <= 1'b1;
          PASS  <= (ERR_CNT == 6'd0);
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_aoi221_arc_exerciser.sv
// Directed bench for aoi221_arc_exerciser with a behavioural AOI221 cell model
// (ideal, ZN tied 0, ZN tied 1, B1 stuck at 0). Honours AOI221_ARC_HALT_EN.
module tb_aoi221_arc_exerciser;

`ifdef AOI221_ARC_HALT_EN
  localparam bit HALT = 1'b1;
`else
  localparam bit HALT = 1'b0;
`endif

  logic       CK = 1'b0;
  logic       RST = 1'b1;
  logic       START = 1'b0;
  logic       ZN_IN;
  logic       A, B1, B2, C1, C2;
  logic       BUSY, DONE, PASS;
  logic [5:0] ERR_CNT;
  logic [4:0] ARC_IDX;

  int mode = 0;
  int total = 0;
  int bad = 0;
  int cyc;

  aoi221_arc_exerciser #(.SETTLE(2)) dut (
    .CK(CK), .RST(RST), .START(START), .ZN_IN(ZN_IN),
    .A(A), .B1(B1), .B2(B2), .C1(C1), .C2(C2),
    .BUSY(BUSY), .DONE(DONE), .PASS(PASS),
    .ERR_CNT(ERR_CNT), .ARC_IDX(ARC_IDX)
  );

  always #5 CK = ~CK;

  logic b1_eff;
  always_comb begin
    b1_eff = (mode == 3) ? 1'b0 : B1;
    if (mode == 1)      ZN_IN = 1'b0;
    else if (mode == 2) ZN_IN = 1'b1;
    else                ZN_IN = ~((C1 & C2) | (b1_eff & B2) | A);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic start_run();
    START = 1'b1;
    @(posedge CK); #1;
    START = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (DONE !== 1'b1 && n < 400) begin
      @(posedge CK); #1;
      n++;
    end
  endtask

  task automatic check_run(input string tag, input int n, input logic [31:0] exp_cyc,
                           input logic [31:0] exp_err, input logic [31:0] exp_pass,
                           input logic [31:0] exp_arc, input logic [31:0] exp_pins);
    chk({tag, "_cycles"}, 32'(n), exp_cyc);
    chk({tag, "_done"}, 32'(DONE), 32'd1);
    chk({tag, "_busy"}, 32'(BUSY), 32'd0);
    chk({tag, "_pass"}, 32'(PASS), exp_pass);
    chk({tag, "_err"}, 32'(ERR_CNT), exp_err);
    chk({tag, "_arc"}, 32'(ARC_IDX), exp_arc);
    chk({tag, "_pins"}, 32'({A, B1, B2, C1, C2}), exp_pins);
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge CK);
    #1;
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_done", 32'(DONE), 32'd0);
    chk("rst_pass", 32'(PASS), 32'd0);
    chk("rst_err", 32'(ERR_CNT), 32'd0);
    chk("rst_arc", 32'(ARC_IDX), 32'd0);
    chk("rst_pins", 32'({A, B1, B2, C1, C2}), 32'd0);
    RST = 1'b0;
    @(posedge CK); #1;

    // Ideal cell: full pass, 190 cycles, ends on arc 20 FALL pattern
    mode = 0;
    start_run();
    chk("ideal_busy_start", 32'(BUSY), 32'd1);
    chk("ideal_pins_start", 32'({A, B1, B2, C1, C2}), 32'd0);
    wait_done(cyc);
    check_run("ideal", cyc, 32'd190, 32'd0, 32'd1, 32'd20, 32'b01010);

    // ZN tied 0: SETUP and FALL fail everywhere
    mode = 1;
    start_run();
    chk("tie0_done_clr", 32'(DONE), 32'd0);
    wait_done(cyc);
    if (HALT) check_run("tie0", cyc, 32'd4, 32'd1, 32'd0, 32'd0, 32'b00000);
    else      check_run("tie0", cyc, 32'd190, 32'd42, 32'd0, 32'd20, 32'b01010);

    // ZN tied 1: every RISE fails
    mode = 2;
    start_run();
    wait_done(cyc);
    if (HALT) check_run("tie1", cyc, 32'd7, 32'd1, 32'd0, 32'd0, 32'b10000);
    else      check_run("tie1", cyc, 32'd190, 32'd21, 32'd0, 32'd20, 32'b01010);

    // B1 stuck at 0 inside the cell: RISE fails on arcs 9..14
    mode = 3;
    start_run();
    wait_done(cyc);
    if (HALT) check_run("b1sa0", cyc, 32'd88, 32'd1, 32'd0, 32'd9, 32'b01100);
    else      check_run("b1sa0", cyc, 32'd190, 32'd6, 32'd0, 32'd20, 32'b01010);

    // Reset mid-run at cycle 50 (arc 5, RISE phase)
    mode = 0;
    start_run();
    repeat (50) begin @(posedge CK); #1; end
    chk("midrst_arc_before", 32'(ARC_IDX), 32'd5);
    chk("midrst_pins_before", 32'({A, B1, B2, C1, C2}), 32'b10110);
    RST = 1'b1;
    @(posedge CK); #1;
    RST = 1'b0;
    chk("midrst_busy", 32'(BUSY), 32'd0);
    chk("midrst_done", 32'(DONE), 32'd0);
    chk("midrst_arc", 32'(ARC_IDX), 32'd0);
    chk("midrst_err", 32'(ERR_CNT), 32'd0);
    chk("midrst_pins", 32'({A, B1, B2, C1, C2}), 32'd0);
    start_run();
    wait_done(cyc);
    check_run("after_rst", cyc, 32'd190, 32'd0, 32'd1, 32'd20, 32'b01010);

    // START re-pulsed during the run and in the FIN cycle: both ignored
    start_run();
    cyc = 0;
    while (DONE !== 1'b1 && cyc < 400) begin
      START = (cyc == 9 || cyc == 189);
      @(posedge CK); #1;
      START = 1'b0;
      cyc++;
      if (cyc == 10) chk("repulse_arc10", 32'(ARC_IDX), 32'd1);
    end
    check_run("repulse", cyc, 32'd190, 32'd0, 32'd1, 32'd20, 32'b01010);
    @(posedge CK); #1;
    chk("repulse_idle_busy", 32'(BUSY), 32'd0);
    chk("repulse_idle_done", 32'(DONE), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
